// File: rtl/uart_pkg.sv
// Shared constants, state encoding and parity helper
// for the UART command master and its receive front end.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_PARITY  = 2'd1;
   localparam logic [1:0] ERR_FRAME   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [3:0] {
      IDLE,
      TX_START,
      TX_DATA,
      TX_PAR,
      TX_STOP,
      GAP,
      RX_WAIT,
      RX_FRAME,
      DONE
   } state_t;

   // Parity bit to send/expect for a byte under the given mode.
   function automatic logic par_bit(input logic [7:0] d, input int mode);
      return (mode == PARITY_EVEN) ? ^d : ~^d;
   endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// UART receive front end: synchronizer, start validation,
// mid-bit sampling and parity/framing checks.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLK_DIV     = 434,
   parameter int PARITY_MODE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       rx,
   output logic       active,
   output logic [7:0] rx_byte,
   output logic       byte_vld,
   output logic [1:0] err
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] MID  = CW'(CLK_DIV / 2 - 1);
   localparam logic [3:0] STOP_IDX =
      (PARITY_MODE != 0) ? 4'd10 : 4'd9;

   logic          s1, s2, s3;
   logic          fall;
   logic [CW-1:0] cnt;
   logic [3:0]    idx;
   logic [7:0]    sh;
   logic          par;
   logic          is_start, is_data, is_par, is_stop;

   assign fall     = s3 & ~s2;
   assign is_start = (idx == 4'd0);
   assign is_data  = (idx >= 4'd1) && (idx <= 4'd8);
   assign is_par   = (PARITY_MODE != 0) && (idx == 4'd9);
   assign is_stop  = (idx == STOP_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= rx;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active   <= 1'b0;
         cnt      <= '0;
         idx      <= '0;
         sh       <= '0;
         par      <= 1'b0;
         rx_byte  <= '0;
         byte_vld <= 1'b0;
         err      <= ERR_NONE;
      end else begin
         byte_vld <= 1'b0;
         err      <= ERR_NONE;
         if (!en) begin
            active <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
         end else if (!active) begin
            if (fall) begin
               active <= 1'b1;
               cnt    <= '0;
               idx    <= '0;
            end
         end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (cnt == MID) begin
               unique case (1'b1)
                  is_start: begin
                     // line back high at mid-start: glitch
                     if (s2) active <= 1'b0;
                     else    idx    <= idx + 1'b1;
                  end
                  is_data: begin
                     sh  <= {s2, sh[7:1]};
                     idx <= idx + 1'b1;
                  end
                  is_par: begin
                     par <= s2;
                     idx <= idx + 1'b1;
                  end
                  is_stop: begin
                     active <= 1'b0;
                     if (!s2)
                        err <= ERR_FRAME;
                     else if (PARITY_MODE != 0 &&
                              par != par_bit(sh, PARITY_MODE))
                        err <= ERR_PARITY;
                     else begin
                        rx_byte  <= sh;
                        byte_vld <= 1'b1;
                     end
                  end
                  default: active <= 1'b0;
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/uart_cmd_master.sv
// UART register command master: serialises address/data
// bytes on tx and collects read replies from rx.
module uart_cmd_master
   import uart_pkg::*;
#(
   parameter int CLK_DIV     = 434,
   parameter int ADDR_BYTES  = 1,
   parameter int DATA_BYTES  = 1,
   parameter int PARITY_MODE = 1,
   parameter int GAP_CYCLES  = 100,
   parameter int RX_TIMEOUT  = 100000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [8*(ADDR_BYTES+DATA_BYTES)-1:0] cmd_in,
   input  logic                          cmd_vld,
   output logic                          cmd_rdy,
   input  logic                          rx,
   output logic                          tx,
   output logic [8*DATA_BYTES-1:0]       rd_data,
   output logic                          rd_vld,
   output logic                          rd_err,
   output logic [1:0]                    err_code,
   output logic                          busy
);

   localparam int NB = ADDR_BYTES + DATA_BYTES;
   localparam int CW = 8 * NB;
   localparam int DW = 8 * DATA_BYTES;
   localparam int BW = $clog2(NB + 1);
   localparam int TW = $clog2(CLK_DIV);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int OW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

   localparam logic [TW-1:0] BIT_LAST = TW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [OW-1:0] TMO_LAST = OW'(RX_TIMEOUT - 1);
   localparam logic [BW-1:0] N_WR     = BW'(NB);
   localparam logic [BW-1:0] N_RD     = BW'(ADDR_BYTES);
   localparam logic [BW-1:0] RX_LAST  = BW'(DATA_BYTES - 1);

   state_t        state;
   logic [CW-1:0] cmd_sh;
   logic          rw;
   logic [7:0]    tx_sh;
   logic [TW-1:0] bcnt;
   logic [3:0]    bit_idx;
   logic [BW-1:0] byte_idx;
   logic [GW-1:0] gcnt;
   logic [OW-1:0] tmo;
   logic [DW-1:0] acc;
   logic [DW-1:0] acc_nx;
   logic [BW-1:0] n_tx;
   logic          bit_end;

   logic          rx_en;
   logic          rx_act;
   logic          rx_vld;
   logic [7:0]    rx_byte;
   logic [1:0]    rx_err;

   assign n_tx    = rw ? N_WR : N_RD;
   assign bit_end = (bcnt == BIT_LAST);
   assign acc_nx  = DW'(acc << 8) | DW'(rx_byte);
   assign cmd_rdy = (state == IDLE);
   assign busy    = (state != IDLE);
   assign rx_en   = (state == RX_WAIT) || (state == RX_FRAME);

   uart_rx_frame #(
      .CLK_DIV     (CLK_DIV),
      .PARITY_MODE (PARITY_MODE)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (rx_en),
      .rx       (rx),
      .active   (rx_act),
      .rx_byte  (rx_byte),
      .byte_vld (rx_vld),
      .err      (rx_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx       <= 1'b1;
         cmd_sh   <= '0;
         rw       <= 1'b0;
         tx_sh    <= '0;
         bcnt     <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         gcnt     <= '0;
         tmo      <= '0;
         acc      <= '0;
         rd_data  <= '0;
         rd_vld   <= 1'b0;
         rd_err   <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         rd_vld <= 1'b0;
         rd_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_vld) begin
                  cmd_sh   <= cmd_in;
                  rw       <= cmd_in[CW-1];
                  err_code <= ERR_NONE;
                  byte_idx <= '0;
                  bcnt     <= '0;
                  tx       <= 1'b0;
                  state    <= TX_START;
               end
            end
            TX_START: begin
               bcnt <= bit_end ? '0 : bcnt + 1'b1;
               if (bit_end) begin
                  tx_sh   <= cmd_sh[CW-1 -: 8];
                  tx      <= cmd_sh[CW-8];
                  bit_idx <= '0;
                  state   <= TX_DATA;
               end
            end
            TX_DATA: begin
               bcnt <= bit_end ? '0 : bcnt + 1'b1;
               if (bit_end) begin
                  if (bit_idx == 4'd7) begin
                     if (PARITY_MODE != 0) begin
                        tx    <= par_bit(cmd_sh[CW-1 -: 8], PARITY_MODE);
                        state <= TX_PAR;
                     end else begin
                        tx    <= 1'b1;
                        state <= TX_STOP;
                     end
                  end else begin
                     tx_sh   <= tx_sh >> 1;
                     tx      <= tx_sh[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            TX_PAR: begin
               bcnt <= bit_end ? '0 : bcnt + 1'b1;
               if (bit_end) begin
                  tx    <= 1'b1;
                  state <= TX_STOP;
               end
            end
            TX_STOP: begin
               bcnt <= bit_end ? '0 : bcnt + 1'b1;
               if (bit_end) begin
                  cmd_sh   <= cmd_sh << 8;
                  byte_idx <= byte_idx + 1'b1;
                  gcnt     <= '0;
                  if (rw && (byte_idx + 1'b1 == n_tx))
                     state <= IDLE;
                  else
                     state <= GAP;
               end
            end
            GAP: begin
               if (gcnt == GAP_LAST) begin
                  if (byte_idx == n_tx) begin
                     byte_idx <= '0;
                     tmo      <= '0;
                     state    <= RX_WAIT;
                  end else begin
                     bcnt  <= '0;
                     tx    <= 1'b0;
                     state <= TX_START;
                  end
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            RX_WAIT: begin
               if (rx_act) begin
                  state <= RX_FRAME;
               end else if (tmo == TMO_LAST) begin
                  rd_err   <= 1'b1;
                  err_code <= ERR_TIMEOUT;
                  state    <= IDLE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            RX_FRAME: begin
               if (rx_err != ERR_NONE) begin
                  rd_err   <= 1'b1;
                  err_code <= rx_err;
                  state    <= IDLE;
               end else if (rx_vld) begin
                  acc <= acc_nx;
                  tmo <= '0;
                  if (byte_idx == RX_LAST) begin
                     rd_data <= acc_nx;
                     rd_vld  <= 1'b1;
                     state   <= DONE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     state    <= RX_WAIT;
                  end
               end else if (!rx_act) begin
                  // false start: keep the running timeout
                  state <= RX_WAIT;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: random commands and replies
// checked against a frame-level model of the UART protocol.
module tb_uart_cmd_master;

   localparam int CD  = 16;
   localparam int NB  = 11;
   localparam int FR  = CD * NB;
   localparam int GP  = 20;
   localparam int TMO = 500;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx    = 1'b1;
   always #5 clk = ~clk;

   logic [15:0] cmd1 = '0;
   logic        vld1 = 1'b0;
   logic        rdy1, tx1, rdv1, rde1, bsy1;
   logic [7:0]  rdd1;
   logic [1:0]  ec1;

   logic [23:0] cmd2 = '0;
   logic        vld2 = 1'b0;
   logic        rdy2, tx2, rdv2, rde2, bsy2;
   logic [15:0] rdd2;
   logic [1:0]  ec2;

   uart_cmd_master #(
      .CLK_DIV(CD), .ADDR_BYTES(1), .DATA_BYTES(1),
      .PARITY_MODE(1), .GAP_CYCLES(GP), .RX_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_in(cmd1), .cmd_vld(vld1),
      .cmd_rdy(rdy1), .rx(rx), .tx(tx1), .rd_data(rdd1),
      .rd_vld(rdv1), .rd_err(rde1), .err_code(ec1), .busy(bsy1)
   );

   uart_cmd_master #(
      .CLK_DIV(CD), .ADDR_BYTES(1), .DATA_BYTES(2),
      .PARITY_MODE(1), .GAP_CYCLES(GP), .RX_TIMEOUT(TMO)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .cmd_in(cmd2), .cmd_vld(vld2),
      .cmd_rdy(rdy2), .rx(rx), .tx(tx2), .rd_data(rdd2),
      .rd_vld(rdv2), .rd_err(rde2), .err_code(ec2), .busy(bsy2)
   );

   int tests = 0;
   int fails = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          vcnt1 = 0, ecnt1 = 0, vcnt2 = 0;
   int unsigned ecyc1 = 0;
   logic [7:0]  vdat1 = '0;
   logic [15:0] vdat2 = '0;
   always @(negedge clk) begin
      if (rdv1) begin vcnt1 <= vcnt1 + 1; vdat1 <= rdd1; end
      if (rde1) begin ecnt1 <= ecnt1 + 1; ecyc1 <= cyc; end
      if (rdv2) begin vcnt2 <= vcnt2 + 1; vdat2 <= rdd2; end
   end

   // odd parity: ones over data+parity must be odd
   function automatic logic exp_par(input logic [7:0] b);
      return ($countones(b) % 2 == 0);
   endfunction

   task automatic issue1(input logic [15:0] c);
      cmd1 = c; vld1 = 1'b1;
      @(negedge clk);
      vld1 = 1'b0;
   endtask

   task automatic issue2(input logic [23:0] c);
      cmd2 = c; vld2 = 1'b1;
      @(negedge clk);
      vld2 = 1'b0;
   endtask

   task automatic cap_frame(input bit sel, output logic [7:0] d,
                            output int unsigned c0);
      logic lv [FR];
      logic bad;
      int   n;
      n = 0; d = '0; c0 = 0; bad = 1'b0;
      while ((sel ? tx2 : tx1) !== 1'b0 && n < 4000) begin
         @(negedge clk); n++;
      end
      tests++;
      if (n >= 4000) begin
         fails++;
         $display("FAIL tx_start: no start bit within %0d cycles", n);
         return;
      end
      c0 = cyc;
      for (int k = 0; k < FR; k++) begin
         if (k > 0) @(negedge clk);
         lv[k] = sel ? tx2 : tx1;
      end
      for (int b = 0; b < NB; b++)
         for (int j = 1; j < CD; j++)
            if (lv[b*CD+j] !== lv[b*CD]) bad = 1'b1;
      for (int i = 0; i < 8; i++) d[i] = lv[(i+1)*CD];
      tests++;
      if (bad || lv[0] !== 1'b0 || lv[9*CD] !== exp_par(d) ||
          lv[10*CD] !== 1'b1) begin
         fails++;
         $display("FAIL tx_frame: start=%b par=%b stop=%b uneven=%b, need 0 %b 1 0",
                  lv[0], lv[9*CD], lv[10*CD], bad, exp_par(d));
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input bit bad_par,
                          input bit stop);
      logic [10:0] f;
      f = {stop, exp_par(b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < NB; i++) begin
         rx = f[i];
         repeat (CD) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({tx1, rdy1, rdd1, rdv1, rde1, ec1, bsy1} !== 15'b11_00000000_00_00_0) begin
         fails++;
         $display("FAIL reset1: got %b need 110000000000000",
                  {tx1, rdy1, rdd1, rdv1, rde1, ec1, bsy1});
      end
      tests++;
      if ({tx2, rdy2, rdd2, rdv2, rde2, ec2, bsy2} !== {2'b11, 21'd0}) begin
         fails++;
         $display("FAIL reset2: got %b need 11 and zeros",
                  {tx2, rdy2, rdd2, rdv2, rde2, ec2, bsy2});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write(input logic [15:0] c);
      logic [7:0]  d;
      int unsigned c0, c1;
      int          v0, e0;
      v0 = vcnt1; e0 = ecnt1;
      issue1(c);
      cap_frame(0, d, c0);
      tests++;
      if (d !== c[15:8]) begin
         fails++;
         $display("FAIL wr_byte0: got %h need %h", d, c[15:8]);
      end
      cap_frame(0, d, c1);
      tests++;
      if (d !== c[7:0]) begin
         fails++;
         $display("FAIL wr_byte1: got %h need %h", d, c[7:0]);
      end
      tests++;
      if (c1 - c0 != FR + GP) begin
         fails++;
         $display("FAIL wr_spacing: got %0d need %0d", c1 - c0, FR + GP);
      end
      tests++;
      if ({rdy1, bsy1} !== 2'b01) begin
         fails++;
         $display("FAIL wr_in_stop: rdy/busy %b need 01", {rdy1, bsy1});
      end
      @(negedge clk);
      tests++;
      if ({rdy1, bsy1, tx1} !== 3'b101) begin
         fails++;
         $display("FAIL wr_idle: rdy/busy/tx %b need 101", {rdy1, bsy1, tx1});
      end
      repeat (4) @(negedge clk);
      tests++;
      if (vcnt1 != v0 || ecnt1 != e0) begin
         fails++;
         $display("FAIL wr_no_pulse: vld %0d err %0d need 0 0",
                  vcnt1 - v0, ecnt1 - e0);
      end
   endtask

   task automatic test_read(input logic [7:0] addr, input logic [7:0] rep,
                            input bit bad_par, input bit stop,
                            input bit glitch);
      logic [7:0]  a, d, old;
      logic [1:0]  code;
      int unsigned c0;
      int          v0, e0;
      v0 = vcnt1; e0 = ecnt1; old = rdd1;
      a = {1'b0, addr[6:0]};
      code = !stop ? 2'd2 : (bad_par ? 2'd1 : 2'd0);
      issue1({a, 8'($urandom)});
      tests++;
      if (ec1 !== 2'd0) begin
         fails++;
         $display("FAIL rd_errclr: err_code %0d need 0", ec1);
      end
      cap_frame(0, d, c0);
      tests++;
      if (d !== a) begin
         fails++;
         $display("FAIL rd_addr: got %h need %h", d, a);
      end
      while (cyc < c0 + FR + GP) @(negedge clk);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      if (glitch) begin
         rx = 1'b0;
         repeat (3) @(negedge clk);
         rx = 1'b1;
         repeat (2 * CD) @(negedge clk);
      end
      send_rx(rep, bad_par, stop);
      repeat (CD) @(negedge clk);
      tests++;
      if (code == 2'd0) begin
         if (vcnt1 != v0 + 1 || ecnt1 != e0 || vdat1 !== rep ||
             rdd1 !== rep || ec1 !== 2'd0) begin
            fails++;
            $display("FAIL rd_ok: vld %0d err %0d data %h code %0d need 1 0 %h 0",
                     vcnt1 - v0, ecnt1 - e0, rdd1, ec1, rep);
         end
      end else begin
         if (ecnt1 != e0 + 1 || vcnt1 != v0 || ec1 !== code ||
             rdd1 !== old) begin
            fails++;
            $display("FAIL rd_error: err %0d vld %0d code %0d data %h need 1 0 %0d %h",
                     ecnt1 - e0, vcnt1 - v0, ec1, rdd1, code, old);
         end
      end
      tests++;
      if ({rdy1, bsy1} !== 2'b10) begin
         fails++;
         $display("FAIL rd_idle: rdy/busy %b need 10", {rdy1, bsy1});
      end
   endtask

   task automatic test_timeout();
      logic [7:0]  d;
      int unsigned c0;
      int          v0, e0, n;
      v0 = vcnt1; e0 = ecnt1; n = 0;
      issue1({1'b0, 7'($urandom), 8'($urandom)});
      cap_frame(0, d, c0);
      while (ecnt1 == e0 && n < FR + GP + TMO + 200) begin
         @(negedge clk); n++;
      end
      repeat (3) @(negedge clk);
      tests++;
      if (ecnt1 != e0 + 1 || ecyc1 != c0 + FR + GP + TMO) begin
         fails++;
         $display("FAIL tmo_timing: pulses %0d at +%0d need 1 at +%0d",
                  ecnt1 - e0, ecyc1 - c0, FR + GP + TMO);
      end
      tests++;
      if (ec1 !== 2'd3 || vcnt1 != v0) begin
         fails++;
         $display("FAIL tmo_code: code %0d vld %0d need 3 0", ec1, vcnt1 - v0);
      end
   endtask

   task automatic test_two_bytes(input logic [7:0] b0, input logic [7:0] b1);
      logic [7:0]  a, d;
      int unsigned c0;
      int          v0;
      v0 = vcnt2;
      a = {1'b0, 7'($urandom)};
      issue2({a, 16'($urandom)});
      cap_frame(1, d, c0);
      tests++;
      if (d !== a) begin
         fails++;
         $display("FAIL rd2_addr: got %h need %h", d, a);
      end
      while (cyc < c0 + FR + GP) @(negedge clk);
      send_rx(b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      send_rx(b1, 1'b0, 1'b1);
      repeat (CD) @(negedge clk);
      tests++;
      if (vcnt2 != v0 + 1 || vdat2 !== {b0, b1} || rdd2 !== {b0, b1} ||
          ec2 !== 2'd0) begin
         fails++;
         $display("FAIL rd2_word: vld %0d data %h code %0d need 1 %h 0",
                  vcnt2 - v0, rdd2, ec2, {b0, b1});
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = {1'b1, 7'($urandom)} & 8'hF7;
      issue1({b, 8'($urandom)});
      repeat (4 * CD) @(negedge clk);
      tests++;
      if ({tx1, bsy1} !== 2'b01) begin
         fails++;
         $display("FAIL rst_pre: tx/busy %b need 01", {tx1, bsy1});
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({tx1, rdy1, bsy1} !== 3'b110) begin
         fails++;
         $display("FAIL rst_mid: tx/rdy/busy %b need 110", {tx1, rdy1, bsy1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      test_write({1'b1, 15'($urandom)});
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write(16'h85A3);
      for (int i = 0; i < 3; i++) test_write({1'b1, 15'($urandom)});
      test_read(8'h12, 8'h5C, 1'b0, 1'b1, 1'b0);
      test_read(8'h12, 8'h5C, 1'b1, 1'b1, 1'b0);
      test_read(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      test_timeout();
      test_read(8'($urandom), 8'h3A, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++)
         test_read(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
      test_two_bytes(8'hBE, 8'hEF);
      test_two_bytes(8'($urandom), 8'($urandom));
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_cmd_master.md
Name: uart_cmd_master

Overview:
- Parametrised UART command master that serialises a multi-byte register command onto tx.
- For read commands, it also receives the reply frames on rx and returns them as one word.
- Sits between the host-side command interface and an external UART register slave.
- Adds configurable byte counts, parity mode, inter-byte gap, RX timeout and error reporting.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit; must be >= 8.
- ADDR_BYTES, 1, number of address bytes sent; bit 7 of the first address byte is the R/W flag (1=write).
- DATA_BYTES, 1, number of data bytes written or read back.
- PARITY_MODE, 1, parity mode: 0 none, 1 odd, 2 even.
- GAP_CYCLES, 100, idle cycles with tx=1 between transmitted bytes, and between the last TX byte and RX wait.
- RX_TIMEOUT, 100000, maximum cycles to wait for each reply start bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_in  in  8*(ADDR_BYTES+DATA_BYTES)  command word {addr bytes, data bytes}; most significant byte is sent first
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  ready to accept a command
- rx  in  1  UART receive line (asynchronous)
- tx  out  1  UART transmit line
- rd_data  out  8*DATA_BYTES  read reply; first received byte lands in the MS byte
- rd_vld  out  1  one-cycle pulse, rd_data is valid
- rd_err  out  1  one-cycle pulse, command aborted
- err_code  out  2  error cause: 0 none, 1 parity, 2 framing, 3 timeout; held until the next accept
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: tx=1, cmd_rdy=1, rd_data=0, rd_vld=0, rd_err=0, err_code=0, busy=0. Reset clears all counters immediately, including mid-frame; tx returns to 1 asynchronously.
- Accept: a command is accepted when cmd_vld && cmd_rdy. cmd_in is latched, cmd_rdy drops on the next cycle and err_code clears. cmd_rdy is high only in IDLE.
- TX frame: start(0), 8 data bits LSB first, parity bit if PARITY_MODE!=0, stop(1). Each bit lasts exactly CLK_DIV cycles. The start bit begins the cycle after accept.
- Parity: odd mode makes the total count of ones over data+parity odd; even mode makes it even.
- Write (R/W=1): sends ADDR_BYTES+DATA_BYTES frames, with GAP_CYCLES between frames. After the final stop bit, returns to IDLE with no rd_vld.
- Read (R/W=0): sends ADDR_BYTES frames only; the data field of cmd_in is ignored. After GAP_CYCLES it enters RX_WAIT. Reply frames that arrive during the gap are ignored.
- RX front end:
  - 2-flop synchronizer on rx; a falling edge on the synchronised signal starts a frame.
  - Start bit resampled at CLK_DIV/2. If it reads 1, it is a false start: return to RX_WAIT without restarting the timeout.
  - Data and parity are sampled at mid-bit.
  - Stop bit sampled at mid-bit: 0 gives a framing error. On 1, the byte completes at that same sample point.
- RX errors: a parity mismatch gives err_code=1 and a framing error gives err_code=2. The first error aborts any remaining bytes, pulses rd_err, sets err_code and returns to IDLE. rd_data keeps its previous value.
- Timeout: the counter runs in RX_WAIT, reloads for each byte, and reaching RX_TIMEOUT gives err_code=3 with the abort behaviour above.
- Read completion: after all DATA_BYTES are received cleanly, rd_data updates and rd_vld pulses one cycle. The FSM returns to IDLE the next cycle and cmd_rdy rises then.
- rx is ignored outside the RX states.
- cmd_vld while busy has no effect; no queuing.
- States: IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, GAP, RX_WAIT, RX_FRAME, DONE. Transitions:
  - IDLE -> TX_START on accept.
  - TX_STOP -> GAP, or TX_STOP -> IDLE after the last write byte.
  - GAP -> TX_START while TX bytes remain, else GAP -> RX_WAIT.
  - RX_WAIT -> RX_FRAME on start edge.
  - RX_FRAME -> RX_WAIT while bytes remain, else RX_FRAME -> DONE.
  - Errors go -> IDLE; DONE -> IDLE.
- Counters: the bit-time counter is $clog2(CLK_DIV) bits and wraps at CLK_DIV-1. The bit index is 4 bits. The byte index is $clog2(ADDR_BYTES+DATA_BYTES+1) bits.

Decomposition:
- Package uart_pkg holds the PARITY_NONE/ODD/EVEN constants, the ERR_* codes, the state enum and a parity function.
- One sub-module, uart_rx_frame, owns the synchronizer, false-start rejection, mid-bit sampling, and parity/framing checks. It outputs byte, byte_vld and err[1:0].

Test Plan (CLK_DIV=16, PARITY_MODE=1, ADDR_BYTES=1, DATA_BYTES=1, GAP_CYCLES=20, RX_TIMEOUT=500):
1. Write cmd_in=16'h85A3 -> tx frames 0x85 (parity 0) then 0xA3 (parity 1), each 176 cycles, with a 20-cycle gap. No rd_vld. cmd_rdy high again after the final stop bit.
2. Read cmd_in=16'h12FF -> tx sends only 0x12. Bench replies 0x5C with parity 1 -> rd_vld pulse, rd_data=8'h5C, err_code=0.
3. Read with reply 0x5C and parity 0 -> rd_err pulse, err_code=1, rd_data unchanged at 8'h5C.
4. Read with reply stop bit 0 -> err_code=2. Read with no reply -> rd_err exactly 500 cycles after RX_WAIT entry, err_code=3.
5. A 3-cycle low glitch on rx in RX_WAIT is rejected as a false start, then a valid 0x3A is received. Repeat with DATA_BYTES=2, replies 0xBE then 0xEF -> rd_data=16'hBEEF.
6. Assert rst_n low mid-TX_DATA -> tx=1, cmd_rdy=1, busy=0 immediately. A new write completes correctly after release.
